// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: request/response handshake with a fixed number of
// wait states, error reporting and pipeline stall. Optional byte enables: DMEM_BYTE_ENABLE_EN.
//
// state | meaning
// IDLE  | ready for a request; accepting latches the request and starts the wait
// BUSY  | waiting out WAIT_STATES cycles; stall asserted, request inputs ignored
// RESP  | one-cycle response; store committed / load data presented on entry
module data_memory_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [63:0]           req_data,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [7:0]            req_byte_en,
`endif
    output logic                  resp_valid,
    output logic [63:0]           resp_data,
    output logic                  resp_error,
    output logic                  stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 8);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("data_memory_responder: WAIT_STATES must be in 0..15");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("data_memory_responder: DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               write_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        data_q;

    logic [63:0]        mem [0:DEPTH-1];

    logic               live_mis;
    logic               live_oor;
    logic               live_err;
    logic [IDX_W-1:0]   live_idx;
    logic [63:0]        live_data;

    logic               accept;
    logic               enter_resp;
    logic               t_write;
    logic               t_err;
    logic [IDX_W-1:0]   t_idx;
    logic [63:0]        t_data;
    logic               mem_we;
    logic [63:0]        rd_word;

    assign live_oor = (req_address >= LIMIT);
    assign live_idx = req_address[IDX_W+2:3];
    assign live_err = live_mis | live_oor;

`ifdef DMEM_BYTE_ENABLE_EN
    logic [7:0]  be_q;
    logic [7:0]  live_be;
    logic [7:0]  t_be;
    logic [15:0] be_wide;

    // Enabled lanes are placed starting at the byte offset; any lane pushed past
    // byte 7 would spill into the next doubleword. Loads are full-word and stay aligned.
    assign be_wide   = {8'h00, req_byte_en} << req_address[2:0];
    assign live_be   = be_wide[7:0];
    assign live_mis  = req_write ? (|be_wide[15:8]) : (|req_address[2:0]);
    assign live_data = req_data << {req_address[2:0], 3'b000};
    assign t_be      = (state == IDLE) ? live_be : be_q;
`else
    assign live_mis  = |req_address[2:0];
    assign live_data = req_data;
`endif

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the RESP-entry edge is the accepting edge itself, so the
    // live request drives the array; otherwise the latched copy does.
    assign t_write = (state == IDLE) ? req_write : write_q;
    assign t_err   = (state == IDLE) ? live_err  : err_q;
    assign t_idx   = (state == IDLE) ? live_idx  : idx_q;
    assign t_data  = (state == IDLE) ? live_data : data_q;

    assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                        ((state == BUSY) && (cnt == 4'd1));

    assign mem_we  = reset && enter_resp && t_write && !t_err;
    assign rd_word = (t_write || t_err) ? 64'h0 : mem[t_idx];

    always_ff @(posedge clock) begin
        if (mem_we) begin
`ifdef DMEM_BYTE_ENABLE_EN
            for (int b = 0; b < 8; b++) begin
                if (t_be[b]) begin
                    mem[t_idx][8*b +: 8] <= t_data[8*b +: 8];
                end
            end
`else
            mem[t_idx] <= t_data;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 64'h0;
            resp_error <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            data_q     <= 64'h0;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q       <= 8'h00;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_data  <= 64'h0;
            resp_error <= 1'b0;
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_error <= t_err;
                resp_data  <= rd_word;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        err_q     <= live_err;
                        idx_q     <= live_idx;
                        data_q    <= live_data;
`ifdef DMEM_BYTE_ENABLE_EN
                        be_q      <= live_be;
`endif
                        cnt       <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            stall <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        stall <= 1'b0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model; a second instance covers zero wait states.
module tb_data_memory_responder;

    localparam int DEPTH = 128;
    localparam int WS    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_write, resp_valid, resp_error, stall;
    logic [63:0] req_address, req_data, resp_data;

    logic        z_valid, z_ready, z_write, z_resp_valid, z_resp_error, z_stall;
    logic [63:0] z_address, z_data, z_resp_data;

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .ADDR_WIDTH(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_byte_en(8'hFF),
`endif
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .stall(stall)
    );

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .ADDR_WIDTH(64)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_address(z_address), .req_data(z_data),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_byte_en(8'hFF),
`endif
        .resp_valid(z_resp_valid), .resp_data(z_resp_data), .resp_error(z_resp_error),
        .stall(z_stall)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: k counts cycles since acceptance (0 = idle).
    logic [63:0] mmem [0:DEPTH-1];
    int          k = 0;
    logic        m_write = 1'b0;
    logic [63:0] m_addr = 64'h0, m_data = 64'h0, e_data = 64'h0;
    logic        e_err = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k = 0;
        end else begin
            if (k == 0) begin
                if (req_valid) begin
                    m_write = req_write;
                    m_addr  = req_address;
                    m_data  = req_data;
                    k = 1;
                end
            end else if (k == WS + 1) begin
                k = 0;
            end else begin
                k++;
            end
            if (k == WS + 1) begin
                e_err  = (m_addr[2:0] != 3'b000) || (m_addr >= 64'(DEPTH * 8));
                e_data = 64'h0;
                if (!e_err) begin
                    if (m_write) mmem[int'(m_addr >> 3)] = m_data;
                    else         e_data = mmem[int'(m_addr >> 3)];
                end
            end
        end
    end

    always @(negedge clock) begin
        check("req_ready",  64'(req_ready),  64'(k == 0));
        check("stall",      64'(stall),      64'(k >= 1 && k <= WS));
        check("resp_valid", 64'(resp_valid), 64'(k == WS + 1));
        if (k == WS + 1) begin
            check("resp_data",  resp_data,        e_data);
            check("resp_error", 64'(resp_error),  64'(e_err));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic do_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic rerr,
                          output int lat, output int nst);
        bit found;
        req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'($urandom);
        req_address = {$urandom, $urandom}; req_data = {$urandom, $urandom};
        lat = 1; nst = 0; rd = 64'h0; rerr = 1'b0; found = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall) nst++;
            if (resp_valid) begin
                rd = resp_data; rerr = resp_error; found = 1;
                break;
            end
            lat++;
            @(negedge clock);
        end
        if (!found) check("txn_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        @(negedge clock);
    endtask

    logic [63:0] rd;
    logic        rerr;
    int          lat, nst;
    logic [63:0] zd;
    int          sel;

    initial begin
        req_valid = 0; req_write = 0; req_address = 0; req_data = 0;
        z_valid = 0; z_write = 0; z_address = 0; z_data = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_stall",      64'(stall),      64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data",  resp_data,       64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < DEPTH; i++)
            do_txn(1'b1, 64'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), rd, rerr, lat, nst);

        do_txn(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, rd, rerr, lat, nst);
        check("st10_latency", 64'(lat), 64'd3);
        check("st10_stall",   64'(nst), 64'd2);
        check("st10_data",    rd,       64'd0);
        check("st10_error",   64'(rerr), 64'd0);
        do_txn(1'b0, 64'h10, 64'h0, rd, rerr, lat, nst);
        check("ld10_latency", 64'(lat), 64'd3);
        check("ld10_stall",   64'(nst), 64'd2);
        check("ld10_data",    rd,       64'hDEAD_BEEF_0123_4567);
        check("ld10_error",   64'(rerr), 64'd0);

        do_txn(1'b0, 64'h0C, 64'h0, rd, rerr, lat, nst);
        check("ld0c_error", 64'(rerr), 64'd1);
        check("ld0c_data",  rd,        64'd0);
        do_txn(1'b0, 64'h08, 64'h0, rd, rerr, lat, nst);
        check("ld08_data",  rd,        64'hC0DE_0000_0000_0001);

        do_txn(1'b1, 64'h400, 64'h1111_2222_3333_4444, rd, rerr, lat, nst);
        check("st400_error", 64'(rerr), 64'd1);
        do_txn(1'b0, 64'h0, 64'h0, rd, rerr, lat, nst);
        check("ld00_data",   rd,        64'hC0DE_0000_0000_0000);
        check("ld00_error",  64'(rerr), 64'd0);

        // Abort a store in BUSY with an asynchronous reset.
        req_valid = 1'b1; req_write = 1'b1; req_address = 64'h20; req_data = 64'h1;
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_req_ready",  64'(req_ready),  64'd1);
        check("arst_stall",      64'(stall),      64'd0);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_data",  resp_data,       64'd0);
        check("arst_resp_error", 64'(resp_error), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        do_txn(1'b0, 64'h20, 64'h0, rd, rerr, lat, nst);
        check("ld20_data", rd, 64'hC0DE_0000_0000_0004);

        // Zero wait states with req_valid held high.
        zd = 64'h5A5A_1234_ABCD_0F0F;
        z_valid = 1'b1; z_write = 1'b1; z_address = 64'h18; z_data = zd;
        @(negedge clock);
        z_write = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("ws0_resp_valid", 64'(z_resp_valid), 64'(i % 2 == 0));
            check("ws0_req_ready",  64'(z_ready),      64'(i % 2 != 0));
            check("ws0_stall",      64'(z_stall),      64'd0);
            if (i % 2 == 0) begin
                check("ws0_resp_data", z_resp_data, (i == 0) ? 64'h0 : zd);
                check("ws0_resp_error", 64'(z_resp_error), 64'd0);
            end
            @(negedge clock);
        end
        z_valid = 1'b0;

        // Randomized traffic; the model decides acceptance every cycle.
        for (int c = 0; c < 2000; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom);
            req_data  = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel <= 6)       req_address = 64'($urandom_range(0, DEPTH - 1)) << 3;
            else if (sel == 7)  req_address = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
            else if (sel == 8)  req_address = 64'(DEPTH * 8) + (64'($urandom_range(0, 15)) << 3);
            else                req_address = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
